// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: access-size encodings,
// FSM state encoding and the byte-enable width.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitR
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication, byte enables and misalignment
// checks for an incoming access, plus lane extraction/extension for load data.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned BW = 32
) (
    input  logic [1:0]      st_offset,
    input  logic [2:0]      st_funct3,
    input  logic            st_is_load,
    input  logic            st_is_store,
    input  logic [BW-1:0]   st_data,
    output logic [BW-1:0]   st_wdata,
    output logic [BE_W-1:0] st_be,
    output logic            st_err,
    input  logic [1:0]      ld_offset,
    input  logic [2:0]      ld_funct3,
    input  logic [BW-1:0]   ld_rdata,
    output logic [BW-1:0]   ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata = st_data;
        st_be    = '0;
        st_err   = 1'b0;
        unique case (st_funct3)
            F3_B, F3_BU: begin
                st_be    = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
                // Unsigned variants exist only for loads.
                st_err   = (st_funct3 == F3_BU) && st_is_store;
            end
            F3_H, F3_HU: begin
                st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
                st_err   = st_offset[0] || ((st_funct3 == F3_HU) && st_is_store);
            end
            F3_W: begin
                st_be  = 4'b1111;
                st_err = (st_offset != 2'b00);
            end
            default: st_err = 1'b1;
        endcase
        if (st_is_load && st_is_store) begin
            st_err = 1'b1;
        end
        if (!st_is_load && !st_is_store) begin
            st_err = 1'b0;
        end
    end

    always_comb begin
        unique case (ld_offset)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        unique case (ld_funct3)
            F3_B:    ld_data = {{(BW-8){ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {{(BW-8){1'b0}}, ld_byte};
            F3_H:    ld_data = {{(BW-16){ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {{(BW-16){1'b0}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access pipeline stage: accepts one EX result, runs the data-memory
// request/response handshake and presents a registered result to WriteBack.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned BW = 32,
    parameter int unsigned OW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [BW-1:0]   ex_alu_out,
    input  logic [BW-1:0]   ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_reg_write,
    input  logic [2:0]      ex_funct3,
    output logic            dm_req,
    output logic            dm_we,
    output logic [OW-1:0]   dm_addr,
    output logic [BW-1:0]   dm_wdata,
    output logic [BE_W-1:0] dm_be,
    input  logic            dm_gnt,
    input  logic            dm_rvalid,
    input  logic [BW-1:0]   dm_rdata,
    output logic [4:0]      mem_rd,
    output logic            mem_reg_write,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [BW-1:0]   wb_data,
    output logic            wb_reg_write,
    output logic            access_err
);

    lsu_state_e    state;
    logic          held_valid;
    logic [4:0]    held_rd;
    logic          held_rw;
    logic [1:0]    held_offset;
    logic [2:0]    held_f3;

    logic          is_mem;
    logic [BW-1:0] st_wdata;
    logic [BE_W-1:0] st_be;
    logic          st_err;
    logic [BW-1:0] ld_data;

    assign is_mem        = ex_mem_read || ex_mem_write;
    assign ex_ready      = (state == StIdle);
    assign mem_rd        = held_valid ? held_rd : 5'd0;
    assign mem_reg_write = held_valid && held_rw;

    lsu_align #(
        .BW (BW)
    ) u_align (
        .st_offset   (ex_alu_out[1:0]),
        .st_funct3   (ex_funct3),
        .st_is_load  (ex_mem_read),
        .st_is_store (ex_mem_write),
        .st_data     (ex_store_data),
        .st_wdata    (st_wdata),
        .st_be       (st_be),
        .st_err      (st_err),
        .ld_offset   (held_offset),
        .ld_funct3   (held_f3),
        .ld_rdata    (dm_rdata),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StIdle;
            held_valid   <= 1'b0;
            held_rd      <= '0;
            held_rw      <= 1'b0;
            held_offset  <= '0;
            held_f3      <= '0;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            dm_be        <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
            access_err   <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            access_err   <= 1'b0;
            // The held op is visible through its wb_valid cycle, then the stage empties.
            if (wb_valid) begin
                held_valid <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (ex_valid) begin
                        held_valid  <= 1'b1;
                        held_rd     <= ex_rd;
                        held_offset <= ex_alu_out[1:0];
                        held_f3     <= ex_funct3;
                        if (!is_mem) begin
                            held_rw      <= ex_reg_write;
                            wb_valid     <= 1'b1;
                            wb_rd        <= ex_rd;
                            wb_data      <= ex_alu_out;
                            wb_reg_write <= ex_reg_write;
                        end else if (st_err) begin
                            held_rw    <= 1'b0;
                            wb_valid   <= 1'b1;
                            wb_rd      <= ex_rd;
                            wb_data    <= '0;
                            access_err <= 1'b1;
                        end else begin
                            held_rw  <= ex_mem_read && ex_reg_write;
                            state    <= StReq;
                            dm_req   <= 1'b1;
                            dm_we    <= ex_mem_write;
                            dm_addr  <= ex_alu_out[OW+1:2];
                            dm_wdata <= st_wdata;
                            dm_be    <= st_be;
                        end
                    end
                end
                StReq: begin
                    if (dm_gnt) begin
                        dm_req <= 1'b0;
                        if (dm_we) begin
                            state    <= StIdle;
                            wb_valid <= 1'b1;
                            wb_rd    <= held_rd;
                        end else begin
                            state <= StWaitR;
                        end
                    end
                end
                StWaitR: begin
                    if (dm_rvalid) begin
                        state        <= StIdle;
                        wb_valid     <= 1'b1;
                        wb_rd        <= held_rd;
                        wb_data      <= ld_data;
                        wb_reg_write <= held_rw;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline: sits between Execution and WriteBack, and owns the data-memory request/response handshake.
- Accepts one EX result per handshake, performs byte/half/word loads and stores with lane steering and sign extension, and presents a registered result to WriteBack.
- Back-pressures Execution while a memory transaction is outstanding, and exports its current rd to data_forwarding and Interlock_Unit.

Parameters:
- BW, 32, data/address bit width
- OW, 10, data-memory word-address width (1024 x 32-bit words)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage can accept (combinational: state==IDLE)
- ex_alu_out  in  BW  effective address, or ALU result for non-memory ops
- ex_store_data  in  BW  rs2 value for stores
- ex_rd  in  5  destination register
- ex_mem_read, ex_mem_write, ex_reg_write  in  1 each  control bits
- ex_funct3  in  3  access size/sign
- dm_req  out  1  memory request (registered)
- dm_we  out  1  write enable
- dm_addr  out  OW  word address
- dm_wdata  out  BW  lane-replicated store data
- dm_be  out  4  byte enables
- dm_gnt  in  1  request accepted
- dm_rvalid  in  1  read data valid
- dm_rdata  in  BW  read word
- mem_rd  out  5  rd of the op held in stage (forwarding)
- mem_reg_write  out  1  held op writes a register
- wb_valid  out  1  one-cycle result pulse
- wb_rd  out  5  destination to WriteBack
- wb_data  out  BW  load data or pass-through ALU result
- wb_reg_write  out  1  WriteBack enable
- access_err  out  1  one-cycle pulse on misaligned/illegal access

Behaviour:
- Reset (rst=0, async): state IDLE; every output register 0; any in-flight transaction is discarded.
- FSM states: IDLE, REQ, WAIT_R.
  - IDLE: on ex_valid (ex_ready=1), capture all EX inputs.
  - A valid load or store goes to REQ; anything else stays in IDLE.
- Non-memory op: accepted in cycle N; wb_valid=1 at N+1 with wb_data=ex_alu_out and wb_reg_write=ex_reg_write.
- REQ:
  - Drive dm_req=1 with stable dm_addr, dm_we, dm_wdata and dm_be until dm_gnt=1.
  - Store + gnt: go to IDLE; wb_valid pulse next cycle with wb_reg_write=0.
  - Load + gnt: go to WAIT_R.
- WAIT_R: hold until dm_rvalid, then go to IDLE and issue the wb_valid pulse next cycle with the extracted data.
  - dm_rvalid is ignored in IDLE and REQ; the earliest legal rvalid is one cycle after gnt.
- Minimum latency with zero-wait memory:
  - Store: accept N, dm_req N+1, wb_valid N+2.
  - Load: dm_req N+1, rvalid N+2, wb_valid N+3.
- dm_addr = ex_alu_out[OW+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(OW+2) bytes.
- funct3 handling:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Loads sign- or zero-extend the addressed lane.
  - Stores replicate byte/half across lanes.
  - dm_be: byte = 1<<addr[1:0]; half = 0011 or 1100; word = 1111.
- Error cases (no dm_req issued): half with addr[0]=1, word with addr[1:0]!=0, store funct3 of 100/101, any other undefined funct3, or mem_read and mem_write both set.
  - Response: access_err=1 and wb_valid=1, both with wb_reg_write=0, in cycle N+1.
- mem_rd and mem_reg_write reflect the captured op from acceptance until its wb_valid cycle; both are 0 when the stage is empty.
- dm_gnt and dm_rvalid arriving in the same cycle while in REQ: take gnt only; rvalid is ignored.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - FSM state encoding
  - byte-enable width constant
- Sub-module lsu_align (combinational):
  - store lane replication and dm_be generation
  - load lane extraction and sign/zero extension
  - misalignment detection

Test Plan:
- ALU pass-through: ex_alu_out=0x1234, rd=5, reg_write=1 -> wb_valid one cycle later with wb_data=0x1234, wb_rd=5; dm_req never asserted.
- SB addr=0x103, data=0xAB, gnt immediate -> dm_addr=0x40, dm_be=1000, dm_wdata=0xABABABAB; wb_valid with wb_reg_write=0.
- LB addr=0x2, dm_rdata=0x00800000 -> wb_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
- LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> dm_req held stable for 4 cycles; ex_ready=0 throughout; wb_valid exactly once with wb_data=dm_rdata.
- LH addr=0x5 -> access_err=1, no dm_req, wb_reg_write=0. SW addr=0x6 -> same response.
- Assert rst=0 while in WAIT_R -> outputs 0 immediately; a later rvalid is ignored; the next load completes normally.
